cs_access_ctrl: RTL and testbench
=================================

Name: cs_access_ctrl

Overview:
- Bus access sequencer for the four-chip select map. It takes single read/write requests from one requester, decodes the upper address bits to one active-low chip select (CS1..CS4), and drives setup/strobe/hold timing with per-chip wait states and an external ready.
- It sits between the local requester and the external chip bus. It replaces the bare combinational select decode with a timed, handshaked access.

Parameters:
- ADDR_W, 8: requester address width; addr_H = addr[ADDR_W-1:ADDR_W-3]
- CHIP1, 3'b100: addr_H code selecting CS1
- CHIP2, 3'b101: addr_H code selecting CS2
- CHIP3, 3'b010: addr_H code selecting CS3
- CHIP4, 3'b011: addr_H code selecting CS4
- SETUP_CYC, 1: cycles in SETUP (CS low, strobe high), >=1
- HOLD_CYC, 1: cycles in HOLD (CS low, strobe high), >=1
- WAIT_CS1 / WAIT_CS2 / WAIT_CS3 / WAIT_CS4, 2 / 2 / 4 / 4: extra strobe cycles per chip; minimum strobe width = WAIT+1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  access request; level, held until ack
- wr  in  1  1 = write, 0 = read
- addr  in  ADDR_W  access address
- wdata  in  8  write data
- rdata  out  8  read data, valid while ack=1
- ack  out  1  one-cycle completion pulse
- err  out  1  error flag, valid only with ack
- busy  out  1  high from SETUP through DONE
- CS1, CS2, CS3, CS4  out  1 each  active-low chip selects
- RD_n, WR_n  out  1 each  active-low strobes
- bus_dout  out  8  write data to the bus
- bus_oe  out  1  bus_dout drive enable
- bus_din  in  8  read data from the bus
- ready_n  in  1  device ready, active low; high extends the strobe

Behaviour:
Reset (async, rst_n low):
- State goes to IDLE immediately, including mid-access.
- CS1..CS4=1, RD_n=WR_n=1, bus_oe=0, bus_dout=0, ack=0, err=0, busy=0, rdata=0.

State machine (states IDLE, SETUP, STROBE, HOLD, DONE):
- IDLE: req=1 at a rising edge (edge 0) latches addr, wr and wdata.
  - Mapped addr_H: go to SETUP.
  - Unmapped addr_H: go straight to DONE with err=1; no CS or strobe is asserted.
- SETUP: SETUP_CYC cycles. Selected CS low, strobes high. On a write, bus_oe=1 and bus_dout=latched wdata.
- STROBE: RD_n (read) or WR_n (write) low.
  - Minimum WAIT_CSx+1 cycles.
  - Exits only on an edge where the minimum count is met and ready_n=0; otherwise extends one cycle at a time.
  - Read: rdata captures bus_din on the exit edge.
- HOLD: HOLD_CYC cycles. CS low, strobes high, bus_oe held for writes.
- DONE: one cycle. ack=1, err valid, all CS high, bus_oe=0. Always returns to IDLE.

Timing and handshake rules:
- Latency with ready_n=0: ack is high in cycle 1+SETUP_CYC+WAIT_CSx+1+HOLD_CYC after edge 0. With defaults this is 6 for CS1/CS2 and 8 for CS3/CS4.
- Exactly one CS is low at any time, and it is constant for the whole access.
- req is not sampled in SETUP through DONE. Dropping req mid-access does not abort it.
- req still high in the IDLE cycle after DONE starts a new access, so the requester must drop req on ack.
- Changes to addr, wr or wdata after edge 0 are ignored.
- rdata holds its last value until the next read capture. err=0 on every successful access.
- Internal counters must be wide enough for max(SETUP_CYC, HOLD_CYC, WAIT_CSx+1). Counter wrap must not occur.

Optional Feature:
Macro: CS_ACC_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYC (default 16).
  - If ready_n remains high for TIMEOUT_CYC cycles after the minimum strobe width is met, STROBE exits to HOLD, then DONE with err=1 and rdata=8'hFF on reads.
  - A write is reported err=1 but was still strobed.
- Undefined: STROBE waits on ready_n indefinitely; err is asserted only for unmapped addresses.

Test Plan:
1. rst_n=0 at any time -> CS1..4=1, RD_n=WR_n=1, bus_oe=0, ack=0, busy=0 within the same cycle (async).
2. Read, addr=8'h80 (CS1), ready_n=0, bus_din=8'hA5, defaults -> CS1 low cycles 1-5, RD_n low cycles 2-4, ack=1, rdata=8'hA5, err=0 in cycle 6; CS2..4 stay high.
3. Write, addr=8'h60 (CS4), wdata=8'h3C -> CS4 low cycles 1-7, WR_n low cycles 2-6, bus_oe=1 and bus_dout=8'h3C cycles 1-7, ack in cycle 8.
4. Unmapped addr=8'h00, read -> ack=1, err=1 in cycle 1; no CS or strobe ever low; busy high only in cycle 1.
5. Read, addr=8'hA0 (CS2), ready_n held high 3 extra cycles past minimum strobe -> RD_n low cycles 2-7, ack in cycle 9. With CS_ACC_TIMEOUT_EN, ready_n stuck high -> ack, err=1, rdata=8'hFF after timeout.
6. rst_n pulsed low during STROBE of a CS3 write -> outputs inactive immediately, no ack. After release, a new CS1 read completes normally with ack in cycle 6.

Source files
------------

// File: rtl/cs_access_ctrl.sv
// Timed, handshaked access sequencer for the four-chip select map (IDLE/SETUP/STROBE/HOLD/DONE).
// Optional macro CS_ACC_TIMEOUT_EN adds a ready_n timeout that ends the access with err=1.
module cs_access_ctrl #(
  parameter int         ADDR_W    = 8,
  parameter logic [2:0] CHIP1     = 3'b100,
  parameter logic [2:0] CHIP2     = 3'b101,
  parameter logic [2:0] CHIP3     = 3'b010,
  parameter logic [2:0] CHIP4     = 3'b011,
  parameter int         SETUP_CYC = 1,
  parameter int         HOLD_CYC  = 1,
  parameter int         WAIT_CS1  = 2,
  parameter int         WAIT_CS2  = 2,
  parameter int         WAIT_CS3  = 4,
`ifdef CS_ACC_TIMEOUT_EN
  parameter int         WAIT_CS4  = 4,
  parameter int         TIMEOUT_CYC = 16
`else
  parameter int         WAIT_CS4  = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic              CS1,
  output logic              CS2,
  output logic              CS3,
  output logic              CS4,
  output logic              RD_n,
  output logic              WR_n,
  output logic [7:0]        bus_dout,
  output logic              bus_oe,
  input  logic [7:0]        bus_din,
  input  logic              ready_n
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_W12 = (WAIT_CS1 > WAIT_CS2) ? WAIT_CS1 : WAIT_CS2;
  localparam int MAX_W34 = (WAIT_CS3 > WAIT_CS4) ? WAIT_CS3 : WAIT_CS4;
  localparam int MAX_W   = (MAX_W12 > MAX_W34) ? MAX_W12 : MAX_W34;
  localparam int MAX_CNT = (MAX_SH > MAX_W + 1) ? MAX_SH : MAX_W + 1;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [CNT_W-1:0]   wait_q, wait_sel;
  logic [1:0]         sel_q, sel;
  logic               hit, wr_q, err_q, timeout_hit, active, strobe;
  logic [7:0]         wdata_q;
  logic [2:0]         addr_h;
  logic               unused_addr;

  assign addr_h      = addr[ADDR_W-1 -: 3];
  assign unused_addr = ^addr[ADDR_W-4:0];

`ifdef CS_ACC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt, to_nx;
`endif

  // NOTE: every signal written in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    hit      = 1'b1;
    sel      = 2'd0;
    wait_sel = CNT_W'(WAIT_CS1);
    case (addr_h)
      CHIP1:   begin sel = 2'd0; wait_sel = CNT_W'(WAIT_CS1); end
      CHIP2:   begin sel = 2'd1; wait_sel = CNT_W'(WAIT_CS2); end
      CHIP3:   begin sel = 2'd2; wait_sel = CNT_W'(WAIT_CS3); end
      CHIP4:   begin sel = 2'd3; wait_sel = CNT_W'(WAIT_CS4); end
      default: hit = 1'b0;
    endcase
  end

  // cnt counts cycles within SETUP/HOLD; in STROBE it saturates at wait_q,
  // the cycle where the minimum strobe width is met.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    timeout_hit = 1'b0;
`ifdef CS_ACC_TIMEOUT_EN
    to_nx       = to_cnt;
`endif
    case (state)
      IDLE: begin
        cnt_nx = '0;
`ifdef CS_ACC_TIMEOUT_EN
        to_nx  = '0;
`endif
        if (req) state_nx = hit ? SETUP : DONE;
      end
      SETUP: begin
        if (cnt == CNT_W'(SETUP_CYC - 1)) begin
          state_nx = STROBE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STROBE: begin
        if (cnt != wait_q) begin
          cnt_nx = cnt + 1'b1;
        end else if (!ready_n) begin
          state_nx = HOLD;
          cnt_nx   = '0;
        end else begin
`ifdef CS_ACC_TIMEOUT_EN
          if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            state_nx    = HOLD;
            cnt_nx      = '0;
            timeout_hit = 1'b1;
          end else begin
            to_nx = to_cnt + 1'b1;
          end
`endif
        end
      end
      HOLD: begin
        if (cnt == CNT_W'(HOLD_CYC - 1)) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the latched request fields are reset too; they are few flops and
      // keep bus_dout and the selects deterministic right after reset.
      state   <= IDLE;
      cnt     <= '0;
      wait_q  <= '0;
      sel_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata   <= '0;
`ifdef CS_ACC_TIMEOUT_EN
      to_cnt  <= '0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
`ifdef CS_ACC_TIMEOUT_EN
      to_cnt <= to_nx;
`endif
      if (state == IDLE && req) begin
        wait_q  <= wait_sel;
        sel_q   <= sel;
        wr_q    <= wr;
        wdata_q <= wdata;
        err_q   <= !hit;
      end
      if (timeout_hit) err_q <= 1'b1;
      if (state == STROBE && state_nx == HOLD && !wr_q)
        rdata <= timeout_hit ? 8'hFF : bus_din;
    end
  end

  // Outputs decode purely from registered state, so they are glitch-free of req/addr.
  always_comb begin
    active   = (state == SETUP) || (state == STROBE) || (state == HOLD);
    strobe   = (state == STROBE);
    busy     = (state != IDLE);
    ack      = (state == DONE);
    err      = (state == DONE) && err_q;
    CS1      = !(active && sel_q == 2'd0);
    CS2      = !(active && sel_q == 2'd1);
    CS3      = !(active && sel_q == 2'd2);
    CS4      = !(active && sel_q == 2'd3);
    RD_n     = !(strobe && !wr_q);
    WR_n     = !(strobe && wr_q);
    bus_oe   = active && wr_q;
    bus_dout = bus_oe ? wdata_q : 8'h00;
  end

endmodule

// File: tb/tb_cs_access_ctrl.sv
// Directed bench for cs_access_ctrl: cycle-by-cycle checks of selects, strobes,
// bus drive and handshake against hand-computed timing for default parameters.
module tb_cs_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, req, wr, ready_n;
  logic [7:0] addr, wdata, bus_din;
  logic [7:0] rdata, bus_dout;
  logic       ack, err, busy, CS1, CS2, CS3, CS4, RD_n, WR_n, bus_oe;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cs_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err), .busy(busy),
    .CS1(CS1), .CS2(CS2), .CS3(CS3), .CS4(CS4), .RD_n(RD_n), .WR_n(WR_n),
    .bus_dout(bus_dout), .bus_oe(bus_oe), .bus_din(bus_din), .ready_n(ready_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " cs"},   {CS4, CS3, CS2, CS1}, 4'hF);
    chk({tag, " strb"}, {RD_n, WR_n}, 2'b11);
    chk({tag, " oe"},   bus_oe, 1'b0);
    chk({tag, " dout"}, bus_dout, 8'h00);
    chk({tag, " ack"},  ack, 1'b0);
    chk({tag, " busy"}, busy, 1'b0);
  endtask

  // One access. Cycle c is the clock period after edge c; edge 0 samples req.
  // chip < 0 means unmapped. ready_n is low from cycle rdy_from onwards.
  task automatic run_access(input string name, input logic [7:0] a, input logic w,
                            input logic [7:0] wd, input logic [7:0] din, input int chip,
                            input int ack_cyc, input int s_first, input int s_last,
                            input int rdy_from, input logic exp_err,
                            input logic [7:0] exp_rdata);
    logic       cs_low, stb, oe;
    logic [3:0] cs_exp;
    addr = a; wr = w; wdata = wd; bus_din = din; req = 1'b1;
    ready_n = (rdy_from > 0);
    @(posedge clk); #1;
    // Request fields change after edge 0 and must be ignored.
    addr = 8'h00; wdata = ~wd; wr = ~w;
    for (int c = 1; c <= ack_cyc; c++) begin
      ready_n = (c < rdy_from);
      cs_low  = (chip >= 0) && (c <= ack_cyc - 1);
      stb     = (c >= s_first) && (c <= s_last);
      oe      = w && cs_low;
      cs_exp  = cs_low ? ~(4'b0001 << chip) : 4'hF;
      chk($sformatf("%s c%0d cs", name, c), {CS4, CS3, CS2, CS1}, cs_exp);
      chk($sformatf("%s c%0d rd_n", name, c), RD_n, !(stb && !w));
      chk($sformatf("%s c%0d wr_n", name, c), WR_n, !(stb && w));
      chk($sformatf("%s c%0d oe", name, c), bus_oe, oe);
      chk($sformatf("%s c%0d dout", name, c), bus_dout, oe ? wd : 8'h00);
      chk($sformatf("%s c%0d busy", name, c), busy, 1'b1);
      chk($sformatf("%s c%0d ack", name, c), ack, c == ack_cyc);
      if (c == ack_cyc) begin
        chk($sformatf("%s err", name), err, exp_err);
        chk($sformatf("%s rdata", name), rdata, exp_rdata);
        req = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk_idle_outputs({name, " after"});
    chk({name, " rdata held"}, rdata, exp_rdata);
    ready_n = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    bus_din = '0; ready_n = 1'b0;
    #3;
    chk_idle_outputs("reset");
    chk("reset rdata", rdata, 8'h00);
    chk("reset err", err, 1'b0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    // name, addr, wr, wdata, din, chip, ack, strobe first/last, ready from, err, rdata
    run_access("rd_cs1",   8'h80, 1'b0, 8'h00, 8'hA5, 0, 6, 2, 4, 0, 1'b0, 8'hA5);
    run_access("wr_cs4",   8'h60, 1'b1, 8'h3C, 8'h11, 3, 8, 2, 6, 0, 1'b0, 8'hA5);
    run_access("unmapped", 8'h00, 1'b0, 8'h00, 8'h22, -1, 1, 99, 0, 0, 1'b1, 8'hA5);
    run_access("rd_cs2_w", 8'hA0, 1'b0, 8'h00, 8'h5A, 1, 9, 2, 7, 7, 1'b0, 8'h5A);
    run_access("rd_cs3",   8'h40, 1'b0, 8'h00, 8'h77, 2, 8, 2, 6, 0, 1'b0, 8'h77);
    run_access("wr_cs2",   8'hBF, 1'b1, 8'hC3, 8'h00, 1, 6, 2, 4, 0, 1'b0, 8'h77);
`ifdef CS_ACC_TIMEOUT_EN
    run_access("rd_cs2_to", 8'hA0, 1'b0, 8'h00, 8'h12, 1, 21, 2, 19, 999, 1'b1, 8'hFF);
`endif

    // Asynchronous reset in the middle of a CS3 write strobe.
    addr = 8'h40; wr = 1'b1; wdata = 8'h99; req = 1'b1; ready_n = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("pre-rst wr_n", WR_n, 1'b0);
    chk("pre-rst cs3", CS3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("async rst");
    chk("async rst rdata", rdata, 8'h00);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst held ack", ack, 1'b0);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs("post rst");
    run_access("rd_cs1_2", 8'h9F, 1'b0, 8'h00, 8'h0F, 0, 6, 2, 4, 0, 1'b0, 8'h0F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
